// File: rtl/sar_search_controller.sv
// Successive-approximation search master.
// Drives trial values onto the comparator's guess input and resolves the
// unknown target MSB-first from the lt/gt/eq flags. An exact match ends the
// search early. A target of zero is confirmed in one extra VERIFY comparison.
module sar_search_controller #(
   parameter  int N  = 8,
   localparam int CW = $clog2(N + 2)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          cmp_lt,
   input  logic          cmp_gt,
   input  logic          cmp_eq,
   output logic [N-1:0]  guess,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  result,
   output logic          found,
   output logic          err,
   output logic [CW-1:0] trials
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRIAL  = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [KW-1:0]   k;          // bit position currently under test
   logic [CW-1:0]   cnt;        // comparisons consumed by the running search
   logic            flags_ok;
   logic [N-1:0]    guess_nxt;

   // The comparator must assert exactly one of its three flags.
   function automatic logic flags_valid(input logic lt, input logic gt, input logic eq);
      return ({lt, gt, eq} == 3'b100) || ({lt, gt, eq} == 3'b010) ||
             ({lt, gt, eq} == 3'b001);
   endfunction

   // Decide bit kk of the current trial, then set the next lower bit (if any).
   function automatic logic [N-1:0] next_trial(input logic [N-1:0] g,
                                               input logic [KW-1:0] kk,
                                               input logic gt);
      logic [N-1:0] n;
      n = g;
      if (gt)
         n[kk] = 1'b0;
      if (kk != '0)
         n[kk - KW'(1)] = 1'b1;
      return n;
   endfunction

   assign flags_ok  = flags_valid(cmp_lt, cmp_gt, cmp_eq);
   assign guess_nxt = next_trial(guess, k, cmp_gt);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode: early exit on match or bad flags, VERIFY after bit 0.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = TRIAL;
         TRIAL: begin
            if (!flags_ok || cmp_eq)
               state_nxt = DONE;
            else if (k == '0)
               state_nxt = VERIFY;
            else
               state_nxt = TRIAL;
         end
         VERIFY:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         TRIAL, VERIFY: busy = 1'b1;
         DONE:          done = 1'b1;
         default:       ;
      endcase
   end

   // Trial value, bit pointer and the held search results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         guess  <= '0;
         k      <= '0;
         cnt    <= '0;
         result <= '0;
         found  <= 1'b0;
         err    <= 1'b0;
         trials <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  guess  <= N'(1) << (N - 1);
                  k      <= KW'(N - 1);
                  cnt    <= '0;
                  found  <= 1'b0;
                  err    <= 1'b0;
                  trials <= '0;
               end
            end
            TRIAL: begin
               cnt <= cnt + CW'(1);
               if (!flags_ok) begin
                  result <= guess;
                  found  <= 1'b0;
                  err    <= 1'b1;
                  trials <= cnt + CW'(1);
               end else if (cmp_eq) begin
                  result <= guess;
                  found  <= 1'b1;
                  trials <= cnt + CW'(1);
               end else begin
                  guess <= guess_nxt;
                  if (k != '0)
                     k <= k - KW'(1);
               end
            end
            VERIFY: begin
               cnt    <= cnt + CW'(1);
               result <= guess;
               found  <= cmp_eq & flags_ok;
               err    <= ~flags_ok;
               trials <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search_controller.sv
// Bench for sar_search_controller: a behavioural comparator drives the flags
// from guess and a target; expected outcomes come from an interval-halving
// reference model of the search.
module tb_sar_search_controller;

   localparam int N  = 8;
   localparam int CW = $clog2(N + 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  target = '0;
   logic          bad = 1'b0;
   logic          cmp_lt, cmp_gt, cmp_eq;
   logic [N-1:0]  guess, result;
   logic          busy, done, found, err;
   logic [CW-1:0] trials;

   int tests = 0;
   int fails = 0;
   int prev_result = 0;

   always #5 clk = ~clk;

   // Combinational comparator; 'bad' forces the inconsistent lt=gt=1 pattern.
   assign cmp_lt = bad ? 1'b1 : (guess < target);
   assign cmp_gt = bad ? 1'b1 : (guess > target);
   assign cmp_eq = bad ? 1'b0 : (guess == target);

   sar_search_controller #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
      .guess(guess), .busy(busy), .done(done), .result(result),
      .found(found), .err(err), .trials(trials)
   );

   // Reference: halve the candidate interval [lo, lo+span) each comparison,
   // probing its midpoint; a single remaining value is confirmed once more.
   // 'fault' names the comparison whose flags are corrupted (0 = none).
   task automatic model(input int tgt, input int fault,
                        output int r, output bit f, output bit e, output int t);
      int lo, span, mid;
      lo = 0; span = 1 << N; t = 0; r = 0; f = 0; e = 0;
      while (1) begin
         t++;
         if (span == 1) begin
            r = lo;
            if (t == fault) e = 1; else f = (lo == tgt);
            return;
         end
         mid = lo + span / 2;
         if (t == fault) begin r = mid; e = 1; return; end
         if (mid == tgt) begin r = mid; f = 1; return; end
         if (mid < tgt) lo = mid;
         span = span / 2;
      end
   endtask

   task automatic run_search(input int tgt, input int fault, input bit poke, input string name);
      int er, et, cyc;
      bit ef, ee, seen;
      model(tgt, fault, er, ef, ee, et);
      target = N'(tgt);
      bad = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0; cyc = 1; bad = (fault == 1);
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL %s busy_after_start got %b want 1", name, busy);
      end
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1; cyc++;
         if (done) seen = 1;
         else begin
            bad = (cyc == fault);
            start = (poke && cyc == 2);
            if (cyc == 2) begin
               tests++;
               if (int'(result) != prev_result) begin
                  fails++; $display("FAIL %s result_held got %0d want %0d", name, result, prev_result);
               end
            end
         end
      end
      bad = 1'b0; start = 1'b0;
      tests++;
      if (!seen) begin
         fails++; $display("FAIL %s timeout got no done want done", name);
      end else begin
         if (int'(result) != er || found !== ef || err !== ee ||
             int'(trials) != et || cyc != et + 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s outcome got r=%0d f=%b e=%b t=%0d lat=%0d busy=%b want r=%0d f=%b e=%b t=%0d lat=%0d busy=0",
                     name, result, found, err, trials, cyc, busy, er, ef, ee, et, et + 1);
         end
      end
      if (poke) start = 1'b1;          // start during DONE must be ignored
      @(posedge clk); #1; start = 1'b0;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL %s done_one_cycle got done=%b busy=%b want 0 0", name, done, busy);
      end
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || int'(result) != er || int'(trials) != et) begin
         fails++; $display("FAIL %s idle_hold got busy=%b done=%b r=%0d t=%0d want 0 0 %0d %0d",
                           name, busy, done, result, trials, er, et);
      end
      prev_result = er;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      tests++;
      if (guess !== '0 || result !== '0 || trials !== '0 || busy !== 1'b0 ||
          done !== 1'b0 || found !== 1'b0 || err !== 1'b0) begin
         fails++; $display("FAIL reset_state got g=%0d r=%0d t=%0d b=%b d=%b f=%b e=%b want all 0",
                           guess, result, trials, busy, done, found, err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0 || guess !== '0) begin
         fails++; $display("FAIL idle_no_start got busy=%b guess=%0d want 0 0", busy, guess);
      end
      prev_result = 0;
   endtask

   task automatic test_basic();
      run_search(128, 0, 0, "t128");
      run_search(96, 0, 0, "t96");
      run_search(111, 0, 0, "t111");
   endtask

   task automatic test_boundaries();
      run_search(0, 0, 0, "t0");
      run_search(255, 0, 0, "t255");
   endtask

   task automatic test_fault();
      run_search(169, 2, 0, "fault169");
   endtask

   task automatic test_reset_mid();
      target = N'(147);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #2; rst_n = 1'b0; #1;
      tests++;
      if (guess !== '0 || result !== '0 || trials !== '0 || busy !== 1'b0 ||
          done !== 1'b0 || found !== 1'b0 || err !== 1'b0) begin
         fails++; $display("FAIL async_reset_mid got g=%0d r=%0d t=%0d b=%b d=%b f=%b e=%b want all 0",
                           guess, result, trials, busy, done, found, err);
      end
      @(negedge clk); rst_n = 1'b1;
      prev_result = 0;
      run_search(85, 0, 0, "after_reset85");
   endtask

   task automatic test_back_to_back();
      run_search(199, 0, 1, "b2b199");
      run_search(220, 0, 1, "b2b220");
   endtask

   task automatic test_random();
      int r, t, fault, tgt;
      bit f, e;
      for (int i = 0; i < 30; i++) begin
         tgt = int'($urandom_range(0, (1 << N) - 1));
         model(tgt, 0, r, f, e, t);
         fault = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, t)) : 0;
         run_search(tgt, fault, ($urandom_range(0, 1) == 1), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_fault();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
